// File: rtl/world_clock_multi.sv
// Multi-zone world clock: one home time shown through a selectable signed hour offset,
// with button editing and an alarm that rings for a bounded number of seconds.
module world_clock_multi #(
   parameter int CLK_HZ    = 50000000,
   parameter int NUM_ZONES = 4,
   parameter int ZONE_W    = 2,
   parameter int RING_SEC  = 60
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   set_mode,
   input  logic                   btn_hour,
   input  logic                   btn_min,
   input  logic                   btn_day,
   input  logic                   btn_zone,
   input  logic                   alarm_en,
   input  logic [NUM_ZONES*6-1:0] zone_offsets,
   output logic [4:0]             hour,
   output logic [5:0]             min,
   output logic [5:0]             sec,
   output logic [2:0]             day,
   output logic                   am_pm,
   output logic [ZONE_W-1:0]      zone,
   output logic [4:0]             a_hour,
   output logic [5:0]             a_min,
   output logic                   ring,
   output logic                   half_sec
);
   // state   | meaning
   // IDLE    | alarm quiet, buttons edit time/alarm
   // RINGING | alarm sounding; ticks count down, any button edge or alarm_en=0 silences it

   localparam int DIV_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_HZ / 2);

   typedef enum logic {IDLE = 1'b0, RINGING = 1'b1} state_t;
   state_t state_q, state_d;

   logic [DIV_W-1:0]  div_q, div_d;
   logic [4:0]        h_q, h_d, a_hour_q, a_hour_d, conv_h;
   logic [5:0]        m_q, m_d, s_q, s_d, a_min_q, a_min_d;
   logic [2:0]        d_q, d_d, conv_d;
   logic [ZONE_W-1:0] zone_q, zone_d;
   logic [7:0]        ring_cnt_q, ring_cnt_d;
   logic              pend_q, pend_d;
   logic [3:0]        sync1_q, sync2_q, sync3_q, btn_rise;  // {zone, day, hour, min}
   logic              any_edge, tick, tick_go;
   logic signed [5:0] off_raw, off;
   logic signed [6:0] sum;

   assign btn_rise = sync2_q & ~sync3_q;
   assign any_edge = |btn_rise;
   assign tick     = (div_q == DIV_LAST);
   // A tick that meets a button edge waits one cycle in pend_q.
   assign tick_go  = (tick | pend_q) & ~any_edge;

   always_comb begin
      div_d      = tick ? '0 : div_q + DIV_W'(1);
      pend_d     = (tick | pend_q) & any_edge;
      h_d        = h_q;
      m_d        = m_q;
      s_d        = s_q;
      d_d        = d_q;
      zone_d     = zone_q;
      a_hour_d   = a_hour_q;
      a_min_d    = a_min_q;
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;

      case (state_q)
         RINGING: if (any_edge || !alarm_en) state_d = IDLE;
         default: begin
            if (btn_rise[3]) begin
               if (!set_mode) zone_d = (zone_q == ZONE_W'(NUM_ZONES - 1)) ? '0 : zone_q + ZONE_W'(1);
            end else if (btn_rise[2]) begin
               if (!set_mode) d_d = (d_q == 3'd6) ? 3'd0 : d_q + 3'd1;
            end else if (btn_rise[1]) begin
               if (set_mode) a_hour_d = (a_hour_q == 5'd23) ? 5'd0 : a_hour_q + 5'd1;
               else          h_d      = (h_q == 5'd23) ? 5'd0 : h_q + 5'd1;
            end else if (btn_rise[0]) begin
               if (set_mode) a_min_d = (a_min_q == 6'd59) ? 6'd0 : a_min_q + 6'd1;
               else begin
                  m_d = (m_q == 6'd59) ? 6'd0 : m_q + 6'd1;
                  s_d = 6'd0;
               end
            end
         end
      endcase

      if (tick_go) begin
         if (s_q != 6'd59) s_d = s_q + 6'd1;
         else begin
            s_d = 6'd0;
            if (m_q != 6'd59) m_d = m_q + 6'd1;
            else begin
               m_d = 6'd0;
               if (h_q != 5'd23) h_d = h_q + 5'd1;
               else begin
                  h_d = 5'd0;
                  d_d = (d_q == 3'd6) ? 3'd0 : d_q + 3'd1;
               end
            end
         end
         if (state_q == RINGING) begin
            if (state_d == RINGING) begin
               if (ring_cnt_q == 8'd1) state_d = IDLE;
               else                    ring_cnt_d = ring_cnt_q - 8'd1;
            end
         end else if (alarm_en && h_d == a_hour_q && m_d == a_min_q && s_d == 6'd0) begin
            state_d    = RINGING;
            ring_cnt_d = 8'(RING_SEC);
         end
      end
   end

   // Out-of-range offsets fall back to home time.
   always_comb begin
      off_raw = zone_offsets[6*int'(zone_q) +: 6];
      off     = (off_raw < -6'sd12 || off_raw > 6'sd14) ? 6'sd0 : off_raw;
      sum     = $signed({2'b00, h_q}) + $signed({off[5], off});
      if (sum < 7'sd0) begin
         conv_h = 5'(sum + 7'sd24);
         conv_d = (d_q == 3'd0) ? 3'd6 : d_q - 3'd1;
      end else if (sum >= 7'sd24) begin
         conv_h = 5'(sum - 7'sd24);
         conv_d = (d_q == 3'd6) ? 3'd0 : d_q + 3'd1;
      end else begin
         conv_h = sum[4:0];
         conv_d = d_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         div_q      <= '0;
         pend_q     <= 1'b0;
         h_q        <= '0;
         m_q        <= '0;
         s_q        <= '0;
         d_q        <= '0;
         zone_q     <= '0;
         a_hour_q   <= '0;
         a_min_q    <= '0;
         ring_cnt_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         sync3_q    <= '0;
         hour       <= '0;
         min        <= '0;
         sec        <= '0;
         day        <= '0;
         am_pm      <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         pend_q     <= pend_d;
         h_q        <= h_d;
         m_q        <= m_d;
         s_q        <= s_d;
         d_q        <= d_d;
         zone_q     <= zone_d;
         a_hour_q   <= a_hour_d;
         a_min_q    <= a_min_d;
         ring_cnt_q <= ring_cnt_d;
         sync1_q    <= {btn_zone, btn_day, btn_hour, btn_min};
         sync2_q    <= sync1_q;
         sync3_q    <= sync2_q;
         hour       <= conv_h;
         min        <= m_q;
         sec        <= s_q;
         day        <= conv_d;
         am_pm      <= set_mode ? (a_hour_q >= 5'd12) : (conv_h >= 5'd12);
      end
   end

   assign zone     = zone_q;
   assign a_hour   = a_hour_q;
   assign a_min    = a_min_q;
   assign ring     = (state_q == RINGING);
   assign half_sec = (div_q >= DIV_HALF);

endmodule

// File: tb/tb_world_clock_multi.sv
// Bench for world_clock_multi: a seconds-of-day reference model feeds an expectation
// queue each clock; a negedge monitor pops and compares, plus directed scenario checks.
module tb_world_clock_multi;
   localparam int CLK_HZ = 10;
   localparam int NZ     = 4;
   localparam int ZW     = 2;
   localparam int RS     = 3;

   logic clk = 1'b0, reset = 1'b0;
   logic set_mode = 0, btn_hour = 0, btn_min = 0, btn_day = 0, btn_zone = 0, alarm_en = 0;
   logic [NZ*6-1:0] zone_offsets;
   logic [4:0] hour, a_hour;
   logic [5:0] min, sec, a_min;
   logic [2:0] day;
   logic am_pm, ring, half_sec;
   logic [ZW-1:0] zone;

   world_clock_multi #(.CLK_HZ(CLK_HZ), .NUM_ZONES(NZ), .ZONE_W(ZW), .RING_SEC(RS)) dut (
      .clk(clk), .reset(reset), .set_mode(set_mode), .btn_hour(btn_hour), .btn_min(btn_min),
      .btn_day(btn_day), .btn_zone(btn_zone), .alarm_en(alarm_en), .zone_offsets(zone_offsets),
      .hour(hour), .min(min), .sec(sec), .day(day), .am_pm(am_pm), .zone(zone),
      .a_hour(a_hour), .a_min(a_min), .ring(ring), .half_sec(half_sec));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] hour; logic [5:0] min; logic [5:0] sec; logic [2:0] day; logic am_pm;
      logic [ZW-1:0] zone; logic [4:0] a_hour; logic [5:0] a_min; logic ring; logic half_sec;
   } obs_t;

   obs_t exp_q[$];
   int total = 0, bad = 0;

   // Reference state: home time kept as seconds of day.
   int m_hs = 0, m_day = 0, m_zone = 0, m_ah = 0, m_am = 0, m_div = 0, m_pend = 0, m_left = 0;
   bit m_ring = 0;
   logic [3:0] hist [3] = '{4'd0, 4'd0, 4'd0};

   function automatic int offset_of(int z);
      logic signed [5:0] r;
      int o;
      r = zone_offsets[z*6 +: 6];
      o = int'(r);
      return (o < -12 || o > 14) ? 0 : o;
   endfunction

   always @(posedge clk) begin
      obs_t e;
      logic [3:0] edges;
      int h, s, dh, dd;
      e = '0;
      if (!reset) begin
         m_hs = 0; m_day = 0; m_zone = 0; m_ah = 0; m_am = 0;
         m_div = 0; m_pend = 0; m_left = 0; m_ring = 0;
         hist = '{4'd0, 4'd0, 4'd0};
      end else begin
         // a press first sampled two edges ago becomes actionable now
         edges = hist[1] & ~hist[2];
         h = m_hs / 3600;
         s = h + offset_of(m_zone);
         if (s < 0)        begin dh = s + 24; dd = (m_day + 6) % 7; end
         else if (s >= 24) begin dh = s - 24; dd = (m_day + 1) % 7; end
         else              begin dh = s;      dd = m_day;           end
         e.hour  = 5'(dh);
         e.min   = 6'((m_hs / 60) % 60);
         e.sec   = 6'(m_hs % 60);
         e.day   = 3'(dd);
         e.am_pm = set_mode ? (m_ah >= 12) : (dh >= 12);

         if (m_div == CLK_HZ - 1) begin m_div = 0; m_pend++; end
         else m_div++;

         if (m_ring) begin
            if (edges != 0 || !alarm_en) m_ring = 0;
         end else if (edges[3]) begin
            if (!set_mode) m_zone = (m_zone + 1) % NZ;
         end else if (edges[2]) begin
            if (!set_mode) m_day = (m_day + 1) % 7;
         end else if (edges[1]) begin
            if (set_mode) m_ah = (m_ah + 1) % 24;
            else m_hs = ((h + 1) % 24) * 3600 + m_hs % 3600;
         end else if (edges[0]) begin
            if (set_mode) m_am = (m_am + 1) % 60;
            else m_hs = h * 3600 + ((((m_hs / 60) % 60) + 1) % 60) * 60;
         end

         if (edges == 0 && m_pend > 0) begin
            m_pend--;
            m_hs++;
            if (m_hs == 86400) begin m_hs = 0; m_day = (m_day + 1) % 7; end
            if (m_ring) begin
               m_left--;
               if (m_left == 0) m_ring = 0;
            end else if (alarm_en && m_hs == m_ah * 3600 + m_am * 60) begin
               m_ring = 1; m_left = RS;
            end
         end
         e.zone = ZW'(m_zone); e.a_hour = 5'(m_ah); e.a_min = 6'(m_am);
         e.ring = m_ring; e.half_sec = (m_div >= CLK_HZ / 2);
         hist[2] = hist[1]; hist[1] = hist[0];
         hist[0] = {btn_zone, btn_day, btn_hour, btn_min};
      end
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      obs_t e, g;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = '{hour, min, sec, day, am_pm, zone, a_hour, a_min, ring, half_sec};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL scoreboard @%0t got h%0d m%0d s%0d d%0d pm%0d z%0d ah%0d am%0d r%0d hs%0d exp h%0d m%0d s%0d d%0d pm%0d z%0d ah%0d am%0d r%0d hs%0d",
               $time, g.hour, g.min, g.sec, g.day, g.am_pm, g.zone, g.a_hour, g.a_min, g.ring, g.half_sec,
               e.hour, e.min, e.sec, e.day, e.am_pm, e.zone, e.a_hour, e.a_min, e.ring, e.half_sec);
         end
      end
   end

   task automatic check(input string name, input longint act, input longint expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic set_btn(input int which, input logic v);
      case (which)
         0: btn_min = v;
         1: btn_hour = v;
         2: btn_day = v;
         default: btn_zone = v;
      endcase
   endtask

   task automatic press(input int which);
      set_btn(which, 1'b1);
      repeat (4) @(negedge clk);
      set_btn(which, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   task automatic set_home(input int hh, input int mm, input int dd);
      int n;
      set_mode = 0;
      n = 0; while (m_day != dd && n < 20) begin press(2); n++; end
      n = 0; while (m_hs / 3600 != hh && n < 30) begin press(1); n++; end
      n = 0; while ((m_hs / 60) % 60 != mm && n < 70) begin press(0); n++; end
      check("set_home_converged",
            longint'(m_hs / 3600 == hh && (m_hs / 60) % 60 == mm && m_day == dd), 1);
   endtask

   initial begin
      int n;
      zone_offsets = '0;
      zone_offsets[5:0]   = 6'd9;
      zone_offsets[11:6]  = 6'b111000;   // -8
      zone_offsets[17:12] = 6'b111011;   // -5
      zone_offsets[23:18] = 6'd0;

      // reset and first tick
      repeat (2) @(negedge clk);
      check("reset_time", longint'({hour, min, sec, day}), 0);
      check("reset_misc", longint'({am_pm, zone, a_hour, a_min, ring, half_sec}), 0);
      reset = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         check($sformatf("half_sec_c%0d", k), longint'(half_sec), longint'(k >= 5 && k <= 9));
         if (k == 10) check("sec_before_tick", longint'(sec), 0);
         if (k == 11) check("sec_after_tick", longint'(sec), 1);
      end

      // alarm edit mode
      set_mode = 1;
      repeat (12) press(1);
      check("alarm_edit_a_hour", longint'(a_hour), 12);
      check("alarm_edit_am_pm", longint'(am_pm), 1);
      check("alarm_edit_home_hour", longint'(hour), 9);
      press(3);
      check("alarm_mode_zone_ignored", longint'(zone), 0);
      repeat (19) press(1);
      check("alarm_hour_7", longint'(a_hour), 7);
      set_mode = 0;

      // zone conversion
      set_home(3, 10, 2);
      repeat (2) @(negedge clk);
      check("z0_hour", longint'(hour), 12);
      check("z0_day", longint'(day), 2);
      check("z0_am_pm", longint'(am_pm), 1);
      check("z0_min", longint'(min), 10);
      press(3);
      check("z1_zone", longint'(zone), 1);
      check("z1_hour", longint'(hour), 19);
      check("z1_day", longint'(day), 1);
      repeat (3) press(3);
      set_home(20, 0, 2);
      repeat (2) @(negedge clk);
      check("z0_wrap_hour", longint'(hour), 5);
      check("z0_wrap_day", longint'(day), 3);

      // full rollover in the zero-offset zone
      repeat (3) press(3);
      set_home(23, 59, 6);
      n = 0;
      while (m_hs != 86399 && n < 800) begin @(negedge clk); n++; end
      check("rollover_reach_59", longint'(n < 800), 1);
      n = 0;
      while (m_hs != 0 && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      check("rollover_time", longint'({hour, min, sec}), 0);
      check("rollover_day", longint'(day), 0);
      check("rollover_am_pm", longint'(am_pm), 0);

      // button edge landing on a tick
      set_home(10, 5, 0);
      n = 0;
      while (!(m_hs % 60 == 30 && m_div == 7) && n < 800) begin @(negedge clk); n++; end
      check("collision_align", longint'(n < 800), 1);
      btn_min = 1;
      repeat (4) @(negedge clk);
      check("collision_min", longint'(min), 6);
      check("collision_sec0", longint'(sec), 0);
      @(negedge clk);
      check("collision_sec1", longint'(sec), 1);
      repeat (20) @(negedge clk);
      btn_min = 0;
      repeat (3) @(negedge clk);
      check("held_single_inc", longint'(min), 6);

      // alarm ring and timeout
      alarm_en = 1;
      set_home(6, 59, 0);
      n = 0;
      while (m_hs != 7 * 3600 && n < 800) begin @(negedge clk); n++; end
      check("ring_on", longint'(ring), 1);
      repeat (25) @(negedge clk);
      check("ring_hold", longint'(ring), 1);
      repeat (6) @(negedge clk);
      check("ring_timeout", longint'(ring), 0);

      // ring silenced by a button that performs no edit
      set_home(6, 59, 0);
      n = 0;
      while (m_hs != 7 * 3600 && n < 800) begin @(negedge clk); n++; end
      check("ring_on_again", longint'(ring), 1);
      press(1);
      check("ring_silenced", longint'(ring), 0);
      check("silence_no_edit", longint'(hour), 7);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         reset = 1'b1;
         if ($urandom_range(0, 5) == 0) begin
            int b;
            b = int'($urandom_range(0, 3));
            case (b)
               0: btn_min = ~btn_min;
               1: btn_hour = ~btn_hour;
               2: btn_day = ~btn_day;
               default: btn_zone = ~btn_zone;
            endcase
         end
         if ($urandom_range(0, 199) == 0) set_mode = ~set_mode;
         if ($urandom_range(0, 149) == 0) alarm_en = ~alarm_en;
         if (i % 500 == 250) zone_offsets = 24'($urandom);
         if ($urandom_range(0, 999) == 0) reset = 1'b0;
      end
      reset = 1'b1;
      {btn_min, btn_hour, btn_day, btn_zone} = '0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
